// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the 8-bit synchronous FIFO and its write-side packer.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int PACK_RATIO = 4;

  // Bit offset of lane k inside a packed word built from w-bit beats.
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/fifo_wr_packer_sat_cnt.sv
// Saturating increment counter: counts up on inc_i and sticks at all-ones.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow IN_W-bit beats into one OUT_W-bit FIFO write, holding the word while wfull.
// Build option: define PACKER_FLUSH_EN to let in_last close a partial word (upper lanes zero).
module fifo_wr_packer
  import fifo_pkg::*;
#(
  parameter int IN_W   = 2,
  parameter int RATIO  = PACK_RATIO,
  parameter int OUT_W  = FIFO_WIDTH,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_last,
  output logic              winc,
  output logic [OUT_W-1:0]  wdata,
  input  logic              wfull,
  output logic [STAT_W-1:0] words_wr
);

  localparam int CNT_W = $clog2(RATIO);

  if (RATIO < 2 || OUT_W != IN_W * RATIO) begin : g_param_err
    $error("fifo_wr_packer: need RATIO >= 2 and OUT_W == IN_W*RATIO");
  end

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             word_vld_q, word_vld_d;
  logic             accept;
  logic             wr_done;
  logic             close_word;

  assign in_ready = !word_vld_q || !wfull;
  assign accept   = in_valid && in_ready;
  assign wr_done  = word_vld_q && !wfull;

`ifdef PACKER_FLUSH_EN
  assign close_word = (cnt_q == CNT_W'(RATIO - 1)) || in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign close_word     = (cnt_q == CNT_W'(RATIO - 1));
`endif

  // A completed write always leaves cnt at 0, so a same-cycle beat naturally lands in lane 0.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    word_vld_d = word_vld_q;
    if (wr_done) begin
      acc_d      = '0;
      word_vld_d = 1'b0;
    end
    if (accept) begin
      acc_d[lane_lsb(int'(cnt_q), IN_W) +: IN_W] = in_data;
      if (close_word) begin
        cnt_d      = '0;
        word_vld_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      word_vld_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      word_vld_q <= word_vld_d;
    end
  end

  assign winc  = word_vld_q;
  assign wdata = acc_q;

  sat_cnt #(
    .W (STAT_W)
  ) u_words_wr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (wr_done),
    .cnt_o (words_wr)
  );

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Scoreboard bench for fifo_wr_packer: a beat-level packing model queues expected words.
module tb_fifo_wr_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_data;
  logic        in_last;
  logic        winc;
  logic [7:0]  wdata;
  logic        wfull;
  logic [15:0] words_wr;

`ifdef PACKER_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  fifo_wr_packer #(
    .IN_W   (2),
    .RATIO  (4),
    .OUT_W  (8),
    .STAT_W (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .winc     (winc),
    .wdata    (wdata),
    .wfull    (wfull),
    .words_wr (words_wr)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         stalls   = 0;
  int         model_words = 0;
  int         m_cnt = 0;
  logic [7:0] m_acc = '0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Completed writes are compared against the queue of modelled words.
  always @(negedge clk) begin
    if (rst_n && winc && !wfull) begin
      if (sb.size() == 0) check("unexpected_write", 32'(wdata), 32'hFFFF_FFFF);
      else check("wdata", 32'(wdata), 32'(sb.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      stalls++;
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("beat_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_acc[m_cnt*2 +: 2] = d;
    m_cnt++;
    if (m_cnt == 4 || (FLUSH && l)) begin
      sb.push_back(m_acc);
      m_acc = '0;
      m_cnt = 0;
      model_words++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_acc = '0;
    m_cnt = 0;
    model_words = 0;
    sb.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         stalls0;
    logic [7:0] held;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    wfull    = 1'b0;
    rst_n    = 1'b0;
    tick(2);
    check("rst_winc", 32'(winc), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_words_wr", 32'(words_wr), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Pack: 01,10,11,00 -> 8'h39
    beat(2'b01, 1'b0); beat(2'b10, 1'b0); beat(2'b11, 1'b0); beat(2'b00, 1'b0);
    check("pack_winc", 32'(winc), 32'd1);
    check("pack_wdata", 32'(wdata), 32'h39);
    check("pack_words0", 32'(words_wr), 32'd0);
    tick(1);
    check("pack_words1", 32'(words_wr), 32'd1);
    check("pack_winc_off", 32'(winc), 32'd0);

    // Stream: 8 beats of 11 with no stall
    stalls0 = stalls;
    for (int i = 0; i < 8; i++) beat(2'b11, 1'b0);
    check("stream_stalls", 32'(stalls - stalls0), 32'd0);
    tick(2);
    check("stream_words", 32'(words_wr), 32'(model_words));

    // Full: hold a word for 5 clocks
    beat(2'b10, 1'b0); beat(2'b01, 1'b0); beat(2'b00, 1'b0); beat(2'b11, 1'b0);
    wfull = 1'b1;
    held = wdata;
    check("full_wdata_model", 32'(held), 32'hC6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_winc", 32'(winc), 32'd1);
      check("full_wdata", 32'(wdata), 32'(held));
      check("full_in_ready", 32'(in_ready), 32'd0);
    end
    check("full_words_held", 32'(words_wr), 32'(model_words - 1));
    @(posedge clk); #1;
    wfull = 1'b0;
    tick(3);
    check("full_words", 32'(words_wr), 32'(model_words));
    check("full_winc_off", 32'(winc), 32'd0);

    // Flush: 11 then 01 with in_last
    beat(2'b11, 1'b0); beat(2'b01, 1'b1);
`ifdef PACKER_FLUSH_EN
    check("flush_winc", 32'(winc), 32'd1);
    check("flush_wdata", 32'(wdata), 32'h07);
`else
    tick(3);
    check("noflush_winc", 32'(winc), 32'd0);
    beat(2'b00, 1'b0); beat(2'b00, 1'b0);
    check("noflush_winc_late", 32'(winc), 32'd1);
    check("noflush_wdata", 32'(wdata), 32'h07);
`endif
    tick(2);
    check("flush_words", 32'(words_wr), 32'(model_words));

    // Reset mid-word: partial word discarded
    beat(2'b01, 1'b0); beat(2'b01, 1'b0); beat(2'b01, 1'b0);
    do_reset();
    check("midrst_winc", 32'(winc), 32'd0);
    check("midrst_words", 32'(words_wr), 32'd0);
    for (int i = 0; i < 4; i++) beat(2'b10, 1'b0);
    check("midrst_wdata", 32'(wdata), 32'hAA);
    tick(2);
    check("midrst_words1", 32'(words_wr), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
